// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder: single-port word memory answering CPU byte/halfword/word loads and stores after a fixed latency
// Ports: clk, rst_n (sync active-low); req_vld/req_wr/req_addr/req_size/req_wdata request in, req_rdy when idle;
//        rsp_vld one-cycle strobe with rsp_rdata (zero-extended load data) and rsp_err (misaligned access).
// Optional macro CPU_MEM_ALIGN_CHECK_EN: misaligned halfword/word requests answer with rsp_err instead of being forced aligned.
module cpu_mem_responder #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_vld,
    input  logic        req_wr,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_wdata,
    output logic        req_rdy,
    output logic        rsp_vld,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [1:0] S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2;
    logic [1:0]    state;
    logic [3:0]    cnt;
    logic          wr;
    logic [AW+1:0] addr;
    logic [1:0]    size;
    logic [31:0]   wdata;
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] idx;
    logic [1:0]    off;
    logic [3:0]    be;
    logic [31:0]   shifted;
    logic [31:0]   lane_d;
    logic          err;
    logic          is_resp;
    logic          unused_addr_hi;
    always_comb begin
        unused_addr_hi = ^req_addr[31:AW+2];
        idx     = addr[AW+1:2];
        // halfword/word offsets are forced down to their natural alignment
        off     = size == 2'b00 ? addr[1:0] : size == 2'b01 ? {addr[1], 1'b0} : 2'b00;
        be      = (size == 2'b00 ? 4'b0001 : size == 2'b01 ? 4'b0011 : 4'b1111) << off;
`ifdef CPU_MEM_ALIGN_CHECK_EN
        err     = size == 2'b01 ? addr[0] : size[1] ? |addr[1:0] : 1'b0;
`else
        err     = 1'b0;
`endif
        shifted = mem[idx] >> {off, 3'b000};
        lane_d  = wdata << {off, 3'b000};
        // outputs are gated by rst_n so they read 0 throughout reset
        is_resp   = rst_n && state == S_RESP;
        req_rdy   = rst_n && state == S_IDLE;
        rsp_vld   = is_resp;
        rsp_err   = is_resp && err;
        rsp_rdata = (!is_resp || wr || err) ? 32'd0 :
                    size == 2'b00 ? {24'd0, shifted[7:0]} :
                    size == 2'b01 ? {16'd0, shifted[15:0]} : shifted;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
        end else if (state == S_IDLE) begin
            if (req_vld) begin
                wr    <= req_wr;
                addr  <= req_addr[AW+1:0];
                size  <= req_size;
                wdata <= req_wdata;
                state <= WAIT_STATES == 0 ? S_RESP : S_WAIT;
                cnt   <= WAIT_STATES == 0 ? 4'd0 : 4'(WAIT_STATES - 1);
            end
        end else if (state == S_WAIT) begin
            state <= cnt == 4'd0 ? S_RESP : S_WAIT;
            cnt   <= cnt == 4'd0 ? 4'd0 : cnt - 4'd1;
        end else begin
            state <= S_IDLE;
        end
    end
    // storage is never reset; a store commits only in a live RESP cycle
    always_ff @(posedge clk) begin
        if (is_resp && wr && !err)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[idx][8*i +: 8] <= lane_d[8*i +: 8];
    end
endmodule

// File: tb/tb_cpu_mem_responder.sv
// tb_cpu_mem_responder: randomized and directed checks of three responders (WAIT_STATES 1, 0, 3) against a byte-array model
module tb_cpu_mem_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic        rst_n [3], req_vld [3], req_wr [3], req_rdy [3], rsp_vld [3], rsp_err [3];
    logic [31:0] req_addr [3], req_wdata [3], rsp_rdata [3];
    logic [1:0]  req_size [3];
    int checks = 0;
    int failures = 0;
    logic [7:0] mb [3][4096];
    function automatic int ws_of(int k);
        return k == 0 ? 1 : k == 1 ? 0 : 3;
    endfunction
    for (genvar k = 0; k < 3; k++) begin : g_dut
        cpu_mem_responder #(.DEPTH(1024), .WAIT_STATES(ws_of(k))) dut (
            .clk(clk), .rst_n(rst_n[k]), .req_vld(req_vld[k]), .req_wr(req_wr[k]),
            .req_addr(req_addr[k]), .req_size(req_size[k]), .req_wdata(req_wdata[k]),
            .req_rdy(req_rdy[k]), .rsp_vld(rsp_vld[k]), .rsp_rdata(rsp_rdata[k]), .rsp_err(rsp_err[k])
        );
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    function automatic int m_off(logic [31:0] a, logic [1:0] sz);
        return sz == 0 ? int'(a[1:0]) : sz == 1 ? int'(a[1:0]) / 2 * 2 : 0;
    endfunction
    function automatic int m_len(logic [1:0] sz);
        return sz == 0 ? 1 : sz == 1 ? 2 : 4;
    endfunction
    function automatic bit m_mis(logic [31:0] a, logic [1:0] sz);
`ifdef CPU_MEM_ALIGN_CHECK_EN
        return (sz == 1 && a[0]) || (sz >= 2 && a[1:0] != 0);
`else
        return 0;
`endif
    endfunction
    function automatic logic [31:0] m_load(int k, logic [31:0] a, logic [1:0] sz);
        int base = int'(a[11:2]) * 4 + m_off(a, sz);
        logic [31:0] v = 0;
        for (int i = 0; i < m_len(sz); i++) v = v + (32'(mb[k][base + i]) << (8 * i));
        return v;
    endfunction
    task automatic m_store(int k, logic [31:0] a, logic [1:0] sz, logic [31:0] wd);
        int base = int'(a[11:2]) * 4 + m_off(a, sz);
        for (int i = 0; i < m_len(sz); i++) mb[k][base + i] = wd[8*i +: 8];
    endtask
    // called at a negedge; returns at the negedge following the response
    task automatic access(input int k, input logic wr, input logic [31:0] a, input logic [1:0] sz,
                          input logic [31:0] wd, output logic [31:0] rd, output logic er);
        int n = 0;
        int lat = 1;
        bit mis = m_mis(a, sz);
        logic [31:0] exp_d = (wr || mis) ? 32'd0 : m_load(k, a, sz);
        while (!req_rdy[k] && n < 50) begin @(negedge clk); n++; end
        check("rdy_wait", 32'(req_rdy[k]), 32'd1);
        req_vld[k] = 1; req_wr[k] = wr; req_addr[k] = a; req_size[k] = sz; req_wdata[k] = wd;
        @(negedge clk);
        req_vld[k] = 0; req_addr[k] = $urandom; req_wdata[k] = $urandom;
        req_size[k] = 2'($urandom); req_wr[k] = 1'($urandom);
        while (!rsp_vld[k] && lat < 40) begin @(negedge clk); lat++; end
        check("latency", 32'(lat), 32'(ws_of(k) + 1));
        rd = rsp_rdata[k];
        er = rsp_err[k];
        check("rdy_in_resp", 32'(req_rdy[k]), 32'd0);
        check("rsp_err", 32'(er), 32'(mis));
        check("rsp_rdata", rd, exp_d);
        if (wr && !mis) m_store(k, a, sz, wd);
        @(negedge clk);
        check("idle_rdy", 32'(req_rdy[k]), 32'd1);
        check("idle_vld", 32'(rsp_vld[k]), 32'd0);
        check("idle_rdata", rsp_rdata[k], 32'd0);
    endtask
    initial begin
        logic [31:0] rd, a;
        logic er;
        logic [1:0] sz;
        for (int k = 0; k < 3; k++) begin
            rst_n[k] = 0; req_vld[k] = 0; req_wr[k] = 0; req_addr[k] = 0; req_size[k] = 0; req_wdata[k] = 0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check("rst_rdy", 32'(req_rdy[k]), 32'd0);
            check("rst_vld", 32'(rsp_vld[k]), 32'd0);
            check("rst_rdata", rsp_rdata[k], 32'd0);
            check("rst_err", 32'(rsp_err[k]), 32'd0);
            rst_n[k] = 1;
        end
        #1;
        for (int k = 0; k < 3; k++) check("post_rst_rdy", 32'(req_rdy[k]), 32'd1);
        @(negedge clk);
        access(0, 1, 32'h10, 2, 32'hDEADBEEF, rd, er);
        access(0, 0, 32'h10, 2, 0, rd, er);
        check("word_rw", rd, 32'hDEADBEEF);
        access(0, 1, 32'h20, 2, 32'h11223344, rd, er);
        access(0, 1, 32'h22, 0, 32'hFFFFFFAA, rd, er);
        access(0, 0, 32'h20, 2, 0, rd, er);
        check("byte_merge", rd, 32'h11AA3344);
        access(0, 0, 32'h22, 1, 0, rd, er);
        check("half_load", rd, 32'h000011AA);
        access(0, 1, 32'h1000, 2, 32'h5, rd, er);
        access(0, 0, 32'h0, 2, 0, rd, er);
        check("wrap", rd, 32'h5);
        access(0, 1, 32'h13, 2, 32'h0BADF00D, rd, er);
`ifdef CPU_MEM_ALIGN_CHECK_EN
        check("mis_err", 32'(er), 32'd1);
        access(0, 0, 32'h10, 2, 0, rd, er);
        check("mis_nowrite", rd, 32'hDEADBEEF);
`else
        check("mis_err", 32'(er), 32'd0);
        access(0, 0, 32'h10, 2, 0, rd, er);
        check("mis_forced", rd, 32'h0BADF00D);
`endif
        for (int k = 0; k < 3; k++) begin
            for (int w = 0; w < 16; w++) access(k, 1, 32'(w * 4), 2, $urandom, rd, er);
            for (int t = 0; t < 60; t++) begin
                a = ($urandom & 32'hFFFFF000) | 32'($urandom_range(0, 15) << 2) | 32'($urandom_range(0, 3));
                sz = 2'($urandom_range(0, 3));
                access(k, 1'($urandom), a, sz, $urandom, rd, er);
            end
        end
        req_vld[1] = 1; req_wr[1] = 0; req_addr[1] = 32'h10; req_size[1] = 2;
        for (int i = 0; i < 6; i++) begin
            check("b2b_rdy", 32'(req_rdy[1]), 32'(i % 2 == 0));
            check("b2b_vld", 32'(rsp_vld[1]), 32'(i % 2 == 1));
            if (i % 2 == 1) check("b2b_rdata", rsp_rdata[1], m_load(1, 32'h10, 2));
            @(negedge clk);
        end
        req_vld[1] = 0;
        @(negedge clk);
        access(2, 1, 32'h3C, 2, 32'hCAFEF00D, rd, er);
        req_vld[2] = 1; req_wr[2] = 1; req_addr[2] = 32'h3C; req_size[2] = 2; req_wdata[2] = 32'h12345678;
        @(negedge clk);
        req_vld[2] = 0; rst_n[2] = 0;
        #1;
        check("abort_rdy_low", 32'(req_rdy[2]), 32'd0);
        @(negedge clk);
        check("abort_vld", 32'(rsp_vld[2]), 32'd0);
        check("abort_rdata", rsp_rdata[2], 32'd0);
        check("abort_err", 32'(rsp_err[2]), 32'd0);
        rst_n[2] = 1;
        #1;
        check("abort_rdy_release", 32'(req_rdy[2]), 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("abort_no_rsp", 32'(rsp_vld[2]), 32'd0);
        end
        access(2, 0, 32'h3C, 2, 0, rd, er);
        check("abort_old_word", rd, 32'hCAFEF00D);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cpu_mem_responder.md
CPU_MEM_RESPONDER -- requirements
Module: cpu_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, meaning number of 32-bit words in the storage array (power of two, at least 4).
REQ-002 SHALL have parameter WAIT_STATES, default 1, meaning extra cycles between request accept and response (0 to 15).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port req_vld, input, 1 bit: CPU presents a memory request.
REQ-006 SHALL have port req_wr, input, 1 bit: 1 means store, 0 means load.
REQ-007 SHALL have port req_addr, input, 32 bits: byte address.
REQ-008 SHALL have port req_size, input, 2 bits: 00 byte, 01 halfword, 10 word; 11 is treated as word.
REQ-009 SHALL have port req_wdata, input, 32 bits: store data, LSB-aligned.
REQ-010 SHALL have port req_rdy, output, 1 bit: responder can accept a request this cycle.
REQ-011 SHALL have port rsp_vld, output, 1 bit: one-cycle response strobe.
REQ-012 SHALL have port rsp_rdata, output, 32 bits: load data, LSB-aligned and zero-extended.
REQ-013 SHALL have port rsp_err, output, 1 bit: access error; see Configuration.

Function
REQ-014 SHALL use a three-state FSM: IDLE, WAIT, RESP.
REQ-015 SHALL drive req_rdy to 1 only in IDLE.
REQ-016 SHALL accept a request only when req_vld and req_rdy are both 1, capturing wr, addr, size and wdata on that edge.
REQ-017 SHALL, on accept, go to RESP if WAIT_STATES is 0, otherwise go to WAIT and load a counter with WAIT_STATES-1.
REQ-018 SHALL decrement the counter in WAIT and go to RESP when it reaches 0.
REQ-019 SHALL assert rsp_vld for exactly one cycle in RESP, so the accept at cycle N produces rsp_vld at cycle N+1+WAIT_STATES, then return to IDLE.
REQ-020 SHALL provide no response backpressure; the CPU must sample rsp_vld in that cycle.
REQ-021 SHALL ignore req_vld outside IDLE, and SHALL NOT use request fields after they are captured.
REQ-022 SHALL form the word index from captured addr[log2(DEPTH)+1:2], so higher address bits wrap around silently.
REQ-023 SHALL commit a store to the array in the RESP cycle, writing only these byte lanes:
  - byte: lane addr[1:0];
  - halfword: lanes 2*addr[1] and 2*addr[1]+1;
  - word: all four lanes.
  Other lanes SHALL be unchanged.
REQ-024 SHALL, for a load, return the addressed byte, halfword or word shifted to bit 0 and zero-extended on rsp_rdata in the RESP cycle.
REQ-025 SHALL drive rsp_rdata to 0 whenever rsp_vld is 0 and in store responses.
REQ-026 SHALL make a load issued after a store to the same word return the updated data.
REQ-027 SHALL NOT reset or initialise the storage array.

Reset
REQ-028 SHALL, while rst_n is 0 at a clock edge, set the FSM to IDLE, clear the counter, and hold req_rdy, rsp_vld, rsp_rdata and rsp_err at 0.
REQ-029 SHALL drive req_rdy to 1 in the first cycle after rst_n returns high.
REQ-030 SHALL, when reset is applied mid-transaction (WAIT or RESP), abort the transaction with no array write and no rsp_vld.

Configuration
REQ-031 SHALL support the macro CPU_MEM_ALIGN_CHECK_EN.
REQ-032 SHALL, with CPU_MEM_ALIGN_CHECK_EN defined, treat a halfword with addr[0]=1, or a word with addr[1:0]!=00, as misaligned, and respond with rsp_vld=1, rsp_err=1, rsp_rdata=0, no array write, and the same latency as a normal access.
REQ-033 SHALL, without CPU_MEM_ALIGN_CHECK_EN, tie rsp_err to 0, force addr[0] to 0 for halfwords and addr[1:0] to 00 for words, and perform the access normally.

Verification
REQ-034 SHALL cover: WAIT_STATES=1; store word 0xDEADBEEF at 0x10 accepted at cycle 5, then load word at 0x10 -> rsp_vld at cycle 7, then load rsp_rdata=0xDEADBEEF.
REQ-035 SHALL cover: after word 0x11223344 at 0x20, store byte 0xAA at 0x22, then load word at 0x20 -> 0x11AA3344; load halfword at 0x22 -> 0x000011AA.
REQ-036 SHALL cover: WAIT_STATES=0; back-to-back req_vld held high -> accepts every 2 cycles, rsp_vld 1 cycle after each accept, req_rdy=0 in the RESP cycles.
REQ-037 SHALL cover: DEPTH=1024; store word 0x5 at 0x1000 -> load word at 0x0 returns 0x00000005 (wrap-around).
REQ-038 SHALL cover: WAIT_STATES=3; store accepted, rst_n low for 1 cycle during WAIT -> no rsp_vld, old word unchanged, req_rdy=1 the cycle after release.
REQ-039 SHALL cover: with CPU_MEM_ALIGN_CHECK_EN, store word at 0x13 -> rsp_err=1 and memory unchanged; without it -> rsp_err=0 and data written at 0x10.
